// File: rtl/data_cache_control_l2.sv
// Control FSM for a 2-way, 256-bit-line L2 data cache with one outstanding request.
// Handles hit/miss resolution, dirty-victim write-back, line fill and hit/miss counters.
module data_cache_control_l2 (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        hit1,
    input  logic        hit2,
    input  logic        dirty1,
    input  logic        dirty2,
    input  logic        lru,
    input  logic        pmem_resp,
    output logic        mem_resp,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic        pmem_addr_sel,
    output logic        load_way1,
    output logic        load_way2,
    output logic        wdata_sel,
    output logic        dirty_in,
    output logic        load_lru,
    output logic        lru_in,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, FILL} state_t;

    state_t state, next_state;
    logic   victim_way, victim_dirty;
    logic   req, hit, miss_dirty;

    assign req        = mem_read | mem_write;
    assign hit        = hit1 | hit2;
    assign miss_dirty = lru ? dirty2 : dirty1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            victim_way   <= 1'b0;
            victim_dirty <= 1'b0;
        end else begin
            state <= next_state;
            if (state == COMPARE && req && !hit) begin
                victim_way   <= lru;
                victim_dirty <= miss_dirty;
            end
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:      if (req) next_state = COMPARE;
            // A dropped request is abandoned here, after any transfer in flight has finished.
            COMPARE:   if (!req)     next_state = IDLE;
                       else if (hit) next_state = IDLE;
                       else          next_state = miss_dirty ? WRITEBACK : FILL;
            WRITEBACK: if (pmem_resp) next_state = FILL;
            FILL:      if (pmem_resp) next_state = COMPARE;
            default:   next_state = IDLE;
        endcase
    end

    // NOTE: every output gets a default before the case so no state leaves one unassigned (no latches).
    always_comb begin
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        pmem_addr_sel = 1'b0;
        load_way1     = 1'b0;
        load_way2     = 1'b0;
        wdata_sel     = 1'b0;
        dirty_in      = 1'b0;
        load_lru      = 1'b0;
        lru_in        = 1'b0;
        unique case (state)
            IDLE: ;
            COMPARE: if (req && hit) begin
                mem_resp = 1'b1;
                load_lru = 1'b1;
                lru_in   = hit1;            // way1 wins when both ways match
                if (mem_write) begin
                    load_way1 = hit1;
                    load_way2 = ~hit1;
                    dirty_in  = 1'b1;
                end
            end
            WRITEBACK: begin
                pmem_write    = 1'b1;
                pmem_addr_sel = 1'b1;
            end
            FILL: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    load_way1 = ~victim_way;
                    load_way2 = victim_way;
                    wdata_sel = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Saturating performance counters; the post-fill retry is simply another COMPARE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
        end else if (state == COMPARE && req) begin
            if (hit && hit_count != 32'hFFFF_FFFF)
                hit_count <= hit_count + 32'd1;
            if (!hit && miss_count != 32'hFFFF_FFFF)
                miss_count <= miss_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_data_cache_control_l2.sv
// Scoreboard bench for data_cache_control_l2: stimulus queues expected output events,
// a negedge monitor pops and compares them whenever the DUT shows activity.
module tb_data_cache_control_l2;

    logic        clk = 1'b0;
    logic        rst, mem_read, mem_write, hit1, hit2, dirty1, dirty2, lru, pmem_resp;
    logic        mem_resp, pmem_read, pmem_write, pmem_addr_sel, load_way1, load_way2;
    logic        wdata_sel, dirty_in, load_lru, lru_in;
    logic [31:0] hit_count, miss_count;

    typedef struct packed {
        logic mem_resp, load_way1, load_way2, wdata_sel, dirty_in;
        logic load_lru, lru_in, pmem_read, pmem_write, pmem_addr_sel;
    } ev_t;

    ev_t  exp_q[$];
    int   checks = 0, failures = 0;
    logic prev_read = 1'b0, prev_write = 1'b0;

    data_cache_control_l2 dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .hit1(hit1), .hit2(hit2), .dirty1(dirty1), .dirty2(dirty2), .lru(lru),
        .pmem_resp(pmem_resp), .mem_resp(mem_resp), .pmem_read(pmem_read),
        .pmem_write(pmem_write), .pmem_addr_sel(pmem_addr_sel), .load_way1(load_way1),
        .load_way2(load_way2), .wdata_sel(wdata_sel), .dirty_in(dirty_in),
        .load_lru(load_lru), .lru_in(lru_in), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic ev_t mk(input logic resp, lw1, lw2, wsel, din, llru, lin, prd, pwr, asel);
        ev_t e;
        e = '{resp, lw1, lw2, wsel, din, llru, lin, prd, pwr, asel};
        return e;
    endfunction

    // Monitor: an event is any strobe cycle or the first cycle of a pmem command.
    always @(negedge clk) begin
        ev_t act, e;
        act = '{mem_resp, load_way1, load_way2, wdata_sel, dirty_in,
                load_lru, lru_in, pmem_read, pmem_write, pmem_addr_sel};
        if (!rst && (mem_resp || load_way1 || load_way2 || load_lru ||
                     (pmem_read && !prev_read) || (pmem_write && !prev_write))) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event: got %b expected none", act);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    failures++;
                    $display("FAIL event: got %b expected %b", act, e);
                end
            end
        end
        prev_read  = pmem_read;
        prev_write = pmem_write;
    end

    // Waits (bounded) at negedges for mem_resp (0), pmem_read (1) or pmem_write (2).
    task automatic wait_sig(input int which, input string name, output int n);
        logic s;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            s = (which == 0) ? mem_resp : (which == 1) ? pmem_read : pmem_write;
        end while (!s && n < 50);
        if (!s) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_resp(input logic set_h1, input logic set_h2);
        next_cycle();
        pmem_resp = 1'b1;
        hit1 = set_h1;
        hit2 = set_h2;
        next_cycle();
        pmem_resp = 1'b0;
    endtask

    task automatic end_req();
        next_cycle();
        {mem_read, mem_write, hit1, hit2} = '0;
    endtask

    // Hit request; expected outputs come from a small model of the hit rules.
    task automatic hit_req(input logic wr, input logic h1, input logic h2, input string name);
        int n;
        exp_q.push_back(mk(1'b1, wr & h1, wr & ~h1 & h2, 1'b0, wr, 1'b1, h1, 1'b0, 1'b0, 1'b0));
        next_cycle();
        mem_read = ~wr; mem_write = wr; hit1 = h1; hit2 = h2;
        wait_sig(0, name, n);
        check({name, "_latency"}, n, 32'd2);
        end_req();
    endtask

    initial begin
        int n;
        {mem_read, mem_write, hit1, hit2, dirty1, dirty2, lru, pmem_resp} = '0;
        rst = 1'b1;
        #12;
        check("reset_outputs", {mem_resp, pmem_read, pmem_write, pmem_addr_sel, load_way1,
              load_way2, wdata_sel, dirty_in, load_lru, lru_in}, 32'd0);
        check("reset_hit_count", hit_count, 32'd0);
        check("reset_miss_count", miss_count, 32'd0);
        rst = 1'b0;

        hit_req(1'b0, 1'b0, 1'b1, "read_hit_way2");
        check("hit_count_1", hit_count, 32'd1);
        check("miss_count_0", miss_count, 32'd0);

        // Clean miss: way1 victim, FILL only.
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        exp_q.push_back(mk(0, 1, 0, 1, 0, 0, 0, 1, 0, 0));
        exp_q.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        next_cycle();
        mem_read = 1'b1; lru = 1'b0; dirty1 = 1'b0; dirty2 = 1'b1;
        wait_sig(1, "clean_fill", n);
        repeat (4) next_cycle();
        pulse_resp(1'b1, 1'b0);
        wait_sig(0, "clean_retry", n);
        check("clean_retry_latency", n, 32'd1);
        end_req();
        check("clean_miss_count", miss_count, 32'd1);
        check("clean_hit_count", hit_count, 32'd2);

        // Dirty miss: way2 victim, WRITEBACK then FILL.
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        exp_q.push_back(mk(0, 0, 1, 1, 0, 0, 0, 1, 0, 0));
        exp_q.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        next_cycle();
        mem_read = 1'b1; lru = 1'b1; dirty1 = 1'b0; dirty2 = 1'b1;
        wait_sig(2, "dirty_wb", n);
        repeat (2) next_cycle();
        check("wb_addr_sel", {pmem_write, pmem_read, pmem_addr_sel}, 32'b101);
        pulse_resp(1'b0, 1'b0);
        wait_sig(1, "dirty_fill", n);
        next_cycle();
        pulse_resp(1'b0, 1'b1);
        wait_sig(0, "dirty_retry", n);
        end_req();
        check("dirty_miss_count", miss_count, 32'd2);
        check("dirty_hit_count", hit_count, 32'd3);

        hit_req(1'b1, 1'b1, 1'b1, "write_hit_both");
        check("write_hit_count", hit_count, 32'd4);

        // Stray pmem_resp while idle must have no effect.
        pulse_resp(1'b0, 1'b0);
        repeat (2) next_cycle();
        check("idle_resp_ignored", {pmem_read, pmem_write, mem_resp}, 32'd0);

        // Reset in the middle of a fill.
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        next_cycle();
        mem_read = 1'b1; lru = 1'b0; dirty1 = 1'b0;
        wait_sig(1, "rst_fill", n);
        next_cycle();
        #2 rst = 1'b1;
        #1;
        check("rst_mid_fill_outputs", {pmem_read, pmem_write, pmem_addr_sel, load_way1,
              load_way2, mem_resp, load_lru}, 32'd0);
        check("rst_mid_fill_hits", hit_count, 32'd0);
        check("rst_mid_fill_misses", miss_count, 32'd0);
        mem_read = 1'b0;
        next_cycle();
        rst = 1'b0;
        hit_req(1'b0, 1'b1, 1'b0, "post_reset_hit");
        check("post_reset_hit_count", hit_count, 32'd1);

        // Saturation of hit_count.
        next_cycle();
        force dut.hit_count = 32'hFFFF_FFFE;
        #1;
        release dut.hit_count;
        for (int i = 0; i < 3; i++) hit_req(1'b0, 1'b1, 1'b0, "sat_hit");
        check("hit_count_saturated", hit_count, 32'hFFFF_FFFF);

        repeat (3) next_cycle();
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
